// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operand width,
// iteration count, op encodings and the FSM state type.
// Configuration macro: MULDIV_DIV_EN (see muldiv_unit / muldiv_step).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN         = 32;
    localparam int MULDIV_STEPS = 32;
    localparam int CNT_W        = $clog2(MULDIV_STEPS);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the multiply/divide sequence.
//   Multiply: acc = {partial_product_hi, multiplier}; add the multiplicand to
//             the upper half when the current multiplier bit is 1, then shift
//             the whole 64-bit accumulator right by one.
//   Divide:   acc = {remainder, dividend/quotient}; shift left one bit into a
//             33-bit partial remainder, trial-subtract the divisor and shift
//             the quotient bit into the low end (restoring division).
// Configuration: MULDIV_DIV_EN enables the divide path and the div_mode port.
// Ports:
//   div_mode  in   1       select divide iteration (MULDIV_DIV_EN only)
//   acc_in    in   2*XLEN  accumulator before this step
//   operand   in   XLEN    multiplicand (multiply) or divisor (divide)
//   acc_out   out  2*XLEN  accumulator after this step
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic                div_mode,
`endif
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;

    always_comb begin
        // 33-bit sum keeps the carry, which becomes the new MSB after the shift
        mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]}
                 + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_in[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]      rem_shift;
    logic [XLEN-1:0]    rem_diff;
    logic               q_bit;
    logic [2*XLEN-1:0]  div_next;

    always_comb begin
        rem_shift = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        q_bit     = (rem_shift >= {1'b0, operand});
        // When the subtraction succeeds the true difference is below the
        // divisor, so the low 32 bits of a modular subtract are exact.
        rem_diff  = rem_shift[XLEN-1:0] - operand;
        div_next  = {(q_bit ? rem_diff : rem_shift[XLEN-1:0]),
                     acc_in[XLEN-2:0], q_bit};
        acc_out   = div_mode ? div_next : mul_next;
    end
`else
    assign acc_out = mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 CALC steps plus one FIX step that applies the
// result signs and writes HI/LO. MTHI/MTLO write HI/LO directly when idle.
// Configuration macro: MULDIV_DIV_EN. When undefined the divider is compiled
// out; DIV/DIVU go straight to FIX, leave HI/LO unchanged and still pulse done.
// Ports:
//   clk     in   1     clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     launch op (ignored while busy)
//   op      in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in   XLEN  operand A (multiplicand/dividend), MTHI/MTLO data
//   rt_val  in   XLEN  operand B (multiplier/divisor)
//   mthi    in   1     write rs_val to HI (idle, no start)
//   mtlo    in   1     write rs_val to LO (idle, no start)
//   hi      out  XLEN  HI register
//   lo      out  XLEN  LO register
//   busy    out  1     operation in flight
//   done    out  1     one-cycle pulse when HI/LO take a new result
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                              input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v,
                                                      input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   step_cnt;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  acc_nxt;
    logic [XLEN-1:0]    operand;
    logic               is_div;
    logic               neg_res;
`ifdef MULDIV_DIV_EN
    logic               neg_rem;
    logic               div_zero;
    logic [XLEN-1:0]    rs_raw;
`endif

    logic               is_signed;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               accept;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    fix_hi;
    logic [XLEN-1:0]    fix_lo;

    // Operand conditioning: |0x80000000| stays 0x80000000 and is then
    // treated as an unsigned magnitude by the iterations.
    always_comb begin
        is_signed = ~op[0];
        a_mag     = neg_if(rs_val, is_signed & rs_val[XLEN-1]);
        b_mag     = neg_if(rt_val, is_signed & rt_val[XLEN-1]);
        accept    = (state == ST_IDLE) && start;
    end

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .div_mode (is_div),
`endif
        .acc_in   (acc),
        .operand  (operand),
        .acc_out  (acc_nxt)
    );

    // Datapath registers: loaded at start, iterated in CALC
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div  <= op[1];
            neg_res <= is_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            if (op[1]) begin
                acc     <= {{XLEN{1'b0}}, a_mag};
                operand <= b_mag;
            end else begin
                acc     <= {{XLEN{1'b0}}, b_mag};
                operand <= a_mag;
            end
`ifdef MULDIV_DIV_EN
            neg_rem  <= is_signed & rs_val[XLEN-1];
            div_zero <= (rt_val == '0);
            rs_raw   <= rs_val;
`endif
        end else if (state == ST_CALC) begin
            acc <= acc_nxt;
        end
    end

    // FIX-stage sign correction
    always_comb begin
        prod   = neg_if_wide(acc, neg_res);
        fix_hi = prod[2*XLEN-1:XLEN];
        fix_lo = prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            if (div_zero) begin
                fix_hi = rs_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_if(acc[2*XLEN-1:XLEN], neg_rem);
                fix_lo = neg_if(acc[XLEN-1:0], neg_res);
            end
        end
`endif
    end

    // Control FSM and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef MULDIV_DIV_EN
                        state <= ST_CALC;
`else
                        state <= op[1] ? ST_FIX : ST_CALC;
`endif
                    end else begin
                        if (mthi) hi <= rs_val;
                        if (mtlo) lo <= rs_val;
                    end
                end
                ST_CALC: begin
                    // 5-bit counter wraps 31->0 on exit
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == CNT_W'(MULDIV_STEPS - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                    hi <= fix_hi;
                    lo <= fix_lo;
`else
                    if (!is_div) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit: reset state, moves, multiply/divide vectors
// with hand-computed results, busy/done timing, busy-time protocol and reset
// abort. Divide expectations follow the MULDIV_DIV_EN build setting.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;

    int vectors = 0;
    int errs    = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one op and follow it to its done cycle. With b2b set the caller
    // is already sitting in the previous op's done cycle.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit b2b);
        int n;
        int ebusy;
        logic [31:0] xh;
        logic [31:0] xl;
        xh    = ehi;
        xl    = elo;
        ebusy = 33;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            xh    = model_hi;
            xl    = model_lo;
            ebusy = 1;
        end
`endif
        if (!b2b) @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        rs_val = 32'hA5A5_5A5A;
        rt_val = 32'h5A5A_A5A5;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 16) check({tag, "_mid_hilo"}, {hi, lo}, {model_hi, model_lo});
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(ebusy));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hilo"}, {hi, lo}, {xh, xl});
        model_hi = xh;
        model_lo = xl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = OP_MULT;
        rs_val = '0;
        rt_val = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // MTHI + MTLO together
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; rs_val = '0;
        check("mthilo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        check("mthilo_nodone", 64'(done), 64'd0);
        model_hi = 32'hCAFE_F00D;
        model_lo = 32'hCAFE_F00D;

        // Multiplies
        run_op("mult_7xm3",   OP_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run_op("multu_x2",    OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("mult_neg0",   OP_MULT,  32'hFFFF_FFFB, 32'd0,        32'h0000_0000, 32'h0000_0000, 1'b0);
        run_op("mult_m1",     OP_MULT,  32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A988, 1'b0);

        // Divides
        run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        check("div_done_one_cycle", 64'(done), 64'd0);
        run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_by0",    OP_DIVU,  32'h0000_0064, 32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0",     OP_DIV,   32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_big",    OP_DIVU,  32'hFFFF_FFFF, 32'd7,        32'h0000_0003, 32'h2492_4924, 1'b0);
        run_op("div_7_m2",    OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("mult_after",  OP_MULT,  32'd100,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
        @(negedge clk);
        check("mult_done_one_cycle", 64'(done), 64'd0);

        // Protocol: MTHI, MULT 3x5 with ignored start/mtlo mid-flight
        mthi = 1'b1; rs_val = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'(model_lo));
        @(negedge clk);
        start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 10) begin
                start = 1'b1; op = OP_DIV; mtlo = 1'b1; rs_val = 32'hDEAD_BEEF; rt_val = 32'd1;
            end else begin
                start = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mtlo = 1'b0;
        check("proto_busy_cycles", 64'(n), 64'd33);
        check("proto_done", 64'(done), 64'd1);
        check("proto_hilo", {hi, lo}, {32'd0, 32'd15});
        @(negedge clk);
        check("proto_no_restart", 64'(busy), 64'd0);
        check("proto_done_low", 64'(done), 64'd0);

        // Reset mid-operation
        start = 1'b1; op = OP_MULT; rs_val = 32'h0000_1234; rt_val = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        check("abort_lo_before", 64'(lo), 64'd15);
        rst_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        check("abort_busy_after", 64'(busy), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage. Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU, runs a 32-step radix-2 shift-add or restoring-divide sequence, and holds the 64-bit result in architectural HI/LO registers. The pipeline control stalls on `busy`. MFHI/MFLO read `hi`/`lo`; MTHI/MTLO write them directly.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk` input 1: clock, all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch operation; accepted only when `busy`=0.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `rs_val` input 32: operand A (multiplicand/dividend), from register-file rd1.
- `rt_val` input 32: operand B (multiplier/divisor), from register-file rd2.
- `mthi` input 1: write `rs_val` to HI.
- `mtlo` input 1: write `rs_val` to LO.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: operation in flight; the pipeline must stall HI/LO consumers.
- `done` output 1: one-cycle pulse when HI/LO take a new result.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on `start`.
  - CALC holds for exactly 32 cycles, driven by a 5-bit step counter that wraps 31→0 on exit.
  - CALC → FIX after step 31.
  - FIX → IDLE always.
- Operand capture on start:
  - Signed ops store |rs|, |rt| and the result-sign flags.
  - Unsigned ops store the raw values.
  - |0x80000000| = 0x80000000, handled as unsigned 32-bit.
- Multiply: 64-bit product accumulator with shift-add, one multiplier bit per step. In FIX, the product is negated if the operand signs differ. HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per step, 33-bit partial remainder.
  - In FIX, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Rounding is truncation toward zero.
  - −2^31 / −1 gives LO=0x80000000, HI=0; no trap.
- Divide by zero (rt=0), both DIV and DIVU: result forced to HI = rs_val as captured (original signed value), LO = 0xFFFFFFFF. Still takes the full latency.
- `start` while `busy` is ignored.
- `mthi`/`mtlo` while `busy` are ignored.
- In IDLE, `start` together with `mthi`/`mtlo` in the same cycle: `start` wins; the move is dropped.
- `mthi` and `mtlo` together: both registers take `rs_val`.
- HI/LO are unchanged until the FIX edge. An in-flight op never exposes partial results on `hi`/`lo`.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, step counter=0.
- Reset mid-operation aborts immediately. No result is written; the state returns to the reset values.
- `start` sampled on edge E0:
  - `busy`=1 in the 33 cycles following E0 (32 CALC + 1 FIX).
  - HI/LO update on the FIX edge.
  - In cycle 34 after E0: `done`=1, `busy`=0, new `hi`/`lo` visible.
- A new `start` is accepted in the `done` cycle, giving back-to-back issue every 34 cycles.
- MTHI/MTLO: single-cycle; the new value is visible the cycle after the edge. `done` is not asserted for moves.
- `hi`/`lo`/`busy`/`done` are registered outputs with no combinational paths from inputs.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath and the 33-bit remainder logic are compiled out.
  - DIV/DIVU `start` is accepted, but the FSM goes IDLE → FIX directly.
  - HI/LO are unchanged.
  - `done` pulses 2 cycles after the start edge.
  - MULT/MULTU are unaffected.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`)
  - FSM state enum
  - `XLEN`
  - `MULDIV_STEPS`=32
- One sub-module, `muldiv_step`: combinational single iteration.
  - Multiply mode: conditional add + shift.
  - Divide mode: trial subtract + shift + quotient bit.
- `muldiv_step` is instantiated once in `muldiv_unit`, which holds the FSM, counter, operand/sign registers and HI/LO.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD (−3) → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` one cycle, `busy` high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=0x64, rt=0 → HI=0x64, LO=0xFFFFFFFF.
- Protocol case:
  - MTHI 0x1234 → HI=0x1234 next cycle.
  - Start MULT 3×5.
  - Pulse `start` (op DIV) and `mtlo` at cycle 10 → both ignored.
  - Result HI=0, LO=15.
  - Deassert `rst_n` at cycle 20 of a second MULT → HI=LO=0, `busy`=0 immediately; no `done`.
